// File: rtl/uart_frame_pkg.sv
// Frame constants and types shared by the UART frame packer and unpacker.
package uart_frame_pkg;

   localparam logic [7:0] HDR_B0 = 8'h55;
   localparam logic [7:0] HDR_B1 = 8'hBB;
   localparam logic [7:0] HDR_B2 = 8'h02;
   localparam logic [7:0] HDR_B3 = 8'h1A;
   localparam logic [7:0] TAIL_B = 8'hF0;

   localparam int FRAME_LEN = 32;
   localparam int PAY_LEN   = 26;
   localparam int CRC_POS   = 30;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CRC     = 2'd1,
      ERR_TAIL    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_H1,
      ST_H2,
      ST_H3,
      ST_PAY,
      ST_CRC,
      ST_TAIL
   } frame_st_t;

   // Header states drop silently on a gap; later states count as aborted frames.
   function automatic logic is_hdr_state(input frame_st_t s);
      return (s == ST_H1) || (s == ST_H2) || (s == ST_H3);
   endfunction

endpackage

// File: rtl/uart_control_ii_unpack_if.sv
// Byte stream, CRC engine hookup and payload bus of the rx frame parser.
// master = the parser, slave = the uart_recv / crc8_d8_rx / application side.
interface uart_control_ii_unpack_if
   import uart_frame_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic                   rx_done;
   logic [7:0]             rx_data;
   logic                   rx_crc_din_vld;
   logic [7:0]             rx_crc_din;
   logic [7:0]             rx_crc_dout;
   logic                   rx_crc_done;
   logic [8*PAY_LEN-1:0]   rx_frame_data;
   logic                   frame_vld;
   logic                   frame_err;
   logic [1:0]             err_code;
   logic [CNT_W-1:0]       ok_cnt;
   logic [CNT_W-1:0]       err_cnt;

   modport master (
      input  rx_done, rx_data, rx_crc_dout,
      output rx_crc_din_vld, rx_crc_din, rx_crc_done,
      output rx_frame_data, frame_vld, frame_err, err_code, ok_cnt, err_cnt
   );

   modport slave (
      output rx_done, rx_data, rx_crc_dout,
      input  rx_crc_din_vld, rx_crc_din, rx_crc_done,
      input  rx_frame_data, frame_vld, frame_err, err_code, ok_cnt, err_cnt
   );
endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte gap counter: expired is high on the clock the gap reaches TIMEOUT_CYC-1.
module uart_rx_timeout #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYC);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                cnt <= '0;
      else if (clear || !run)    cnt <= '0;
      else if (!expired)         cnt <= cnt + 1'b1;
   end

   assign expired = run && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_control_ii_unpack.sv
// UART receive frame parser: header hunt, 26-byte payload capture, CRC8 and tail check,
// double-buffered payload output with good/error frame counters.
module uart_control_ii_unpack
   import uart_frame_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   uart_control_ii_unpack_if.master bus
);
   localparam int IDX_W = $clog2(PAY_LEN);

   frame_st_t               state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [PAY_LEN-1:0][7:0] shadow;
   logic                    shd_we;
   logic                    load_out;
   logic                    hunt;
   logic                    feed;
   logic                    abort;
   err_code_t               cause;
   logic                    expired;
   logic                    crc_done_nxt;

   logic                    crc_vld;
   logic [7:0]              crc_din;
   logic                    crc_done;
   logic [8*PAY_LEN-1:0]    frame_data;
   logic                    fvld;
   logic                    ferr;
   err_code_t               ecode;
   logic [CNT_W-1:0]        ok_q;
   logic [CNT_W-1:0]        err_q;

   uart_rx_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.rx_done),
      .run     (state != ST_IDLE),
      .expired (expired)
   );

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      shd_we       = 1'b0;
      load_out     = 1'b0;
      hunt         = 1'b0;
      feed         = 1'b0;
      abort        = 1'b0;
      cause        = ecode;
      crc_done_nxt = 1'b0;

      if (bus.rx_done) begin
         unique case (state)
            ST_IDLE: begin
               if (bus.rx_data == HDR_B0) begin
                  state_nxt    = ST_H1;
                  crc_done_nxt = 1'b1;
               end
            end
            ST_H1: begin
               if (bus.rx_data == HDR_B1) state_nxt = ST_H2;
               else                       hunt      = 1'b1;
            end
            ST_H2: begin
               if (bus.rx_data == HDR_B2) begin
                  state_nxt = ST_H3;
                  feed      = 1'b1;
               end else begin
                  hunt = 1'b1;
               end
            end
            ST_H3: begin
               if (bus.rx_data == HDR_B3) begin
                  state_nxt = ST_PAY;
                  idx_nxt   = '0;
                  feed      = 1'b1;
               end else begin
                  hunt = 1'b1;
               end
            end
            ST_PAY: begin
               feed   = 1'b1;
               shd_we = 1'b1;
               if (idx == IDX_W'(PAY_LEN - 1)) state_nxt = ST_CRC;
               else                            idx_nxt   = idx + 1'b1;
            end
            ST_CRC: begin
               // The CRC byte itself is compared, never fed to the engine.
               if (bus.rx_data != bus.rx_crc_dout) begin
                  abort = 1'b1;
                  cause = ERR_CRC;
               end else begin
                  state_nxt = ST_TAIL;
               end
            end
            ST_TAIL: begin
               if (bus.rx_data == TAIL_B) begin
                  load_out     = 1'b1;
                  state_nxt    = ST_IDLE;
                  crc_done_nxt = 1'b1;
               end else begin
                  abort = 1'b1;
                  cause = ERR_TAIL;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (expired) begin
         if (is_hdr_state(state)) begin
            state_nxt    = ST_IDLE;
            crc_done_nxt = 1'b1;
         end else if (state != ST_IDLE) begin
            abort = 1'b1;
            cause = ERR_TIMEOUT;
         end
      end

      // A broken header may itself be the start of the next one.
      if (hunt) begin
         state_nxt    = (bus.rx_data == HDR_B0) ? ST_H1 : ST_IDLE;
         crc_done_nxt = (bus.rx_data == HDR_B0);
      end
      if (abort) begin
         state_nxt    = ST_IDLE;
         crc_done_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         shadow     <= '0;
         crc_vld    <= 1'b0;
         crc_din    <= 8'h00;
         crc_done   <= 1'b0;
         frame_data <= '0;
         fvld       <= 1'b0;
         ferr       <= 1'b0;
         ecode      <= ERR_NONE;
         ok_q       <= '0;
         err_q      <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         if (shd_we) shadow[idx] <= bus.rx_data;
         crc_vld  <= feed;
         crc_din  <= feed ? bus.rx_data : 8'h00;
         crc_done <= crc_done_nxt;
         fvld     <= load_out;
         ferr     <= abort;
         if (load_out) begin
            frame_data <= shadow;
            ok_q       <= (ok_q == {CNT_W{1'b1}}) ? ok_q : ok_q + 1'b1;
         end
         if (abort) begin
            ecode <= cause;
            err_q <= (err_q == {CNT_W{1'b1}}) ? err_q : err_q + 1'b1;
         end
      end
   end

   assign bus.rx_crc_din_vld = crc_vld;
   assign bus.rx_crc_din     = crc_din;
   assign bus.rx_crc_done    = crc_done;
   assign bus.rx_frame_data  = frame_data;
   assign bus.frame_vld      = fvld;
   assign bus.frame_err      = ferr;
   assign bus.err_code       = ecode;
   assign bus.ok_cnt         = ok_q;
   assign bus.err_cnt        = err_q;

endmodule

// File: doc/uart_control_ii_unpack.md
Name: uart_control_ii_unpack

Overview:
Receive-side frame parser for the UART link; the counterpart of the 32-byte frame packer. It consumes bytes from uart_recv, hunts for the header, collects 26 payload bytes and checks CRC8 through the shared crc8_d8 interface. It also checks the tail byte. A validated payload is presented as a stable, double-buffered bus to the application.
Frame layout, bytes 0..31: 55 BB 02 1A, payload[0..25], CRC, F0. The CRC covers bytes 2..29.

Parameters:
TIMEOUT_CYC, 50000, maximum clocks allowed between consecutive bytes inside a frame (1 ms at 50 MHz).
CNT_W, 16, width of the good-frame and error-frame counters.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
rx_done  in  1  one-cycle strobe from uart_recv: rx_data valid. Strobes are at least 4 clocks apart.
rx_data  in  8  received byte.
rx_crc_din_vld  out  1  byte valid to the crc8_d8_rx instance.
rx_crc_din  out  8  byte to the CRC block.
rx_crc_dout  in  8  running CRC. Updated 1 clock after rx_crc_din_vld.
rx_crc_done  out  1  one-cycle pulse that clears the CRC block.
rx_frame_data  out  208  payload bus; payload[k] sits at [8k+7:8k].
frame_vld  out  1  one-cycle pulse: good frame latched into rx_frame_data.
frame_err  out  1  one-cycle pulse: frame aborted.
err_code  out  2  cause of the last error, held until the next error. 1 = CRC, 2 = tail, 3 = timeout.
ok_cnt  out  CNT_W  count of good frames; saturates at maximum.
err_cnt  out  CNT_W  count of aborted frames; saturates at maximum.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including rx_frame_data, err_code and both counters. The shadow buffer and the byte index are cleared.
- All outputs are registered. The only event is rx_done; nothing advances without it.
- FSM states: IDLE, H1, H2, H3, PAY, CRC, TAIL.
  - IDLE: byte 55 -> H1, and pulse rx_crc_done. Any other byte stays in IDLE.
  - H1: BB -> H2.
  - H2: 02 -> H3.
  - H3: 1A -> PAY, with idx cleared to 0.
  - Header mismatch in H1, H2 or H3:
    - byte 55 -> H1 (re-sync) and pulse rx_crc_done;
    - any other byte -> IDLE;
    - no frame_err, no counter change.
  - PAY: each byte is written to shadow[idx] and idx increments. After idx 25 -> CRC.
  - CRC: rx_data != rx_crc_dout -> abort, err_code 1. Otherwise -> TAIL. The CRC byte is not fed to the CRC block.
  - TAIL: F0 -> frame complete. Any other byte -> abort, err_code 2.
- CRC feed:
  - Accepted bytes in H2, H3 and PAY raise rx_crc_din_vld for exactly 1 clock, the clock after rx_done, with rx_crc_din = that byte.
  - Otherwise rx_crc_din_vld = 0 and rx_crc_din = 0.
- Frame completion and abort:
  - On completion, on the clock after the tail rx_done:
    - the shadow buffer is copied into rx_frame_data;
    - frame_vld = 1 for 1 clock;
    - ok_cnt increments;
    - rx_crc_done pulses;
    - state -> IDLE.
  - On abort:
    - frame_err = 1 for 1 clock;
    - err_code is updated;
    - err_cnt increments;
    - rx_crc_done pulses;
    - state -> IDLE;
    - rx_frame_data is unchanged.
- Timeout:
  - The gap counter clears on every rx_done and counts in every state other than IDLE.
  - If it reaches TIMEOUT_CYC-1 in PAY, CRC or TAIL -> abort, err_code 3.
  - If it reaches TIMEOUT_CYC-1 in H1, H2 or H3 -> silent return to IDLE, with an rx_crc_done pulse.
  - If rx_done coincides with the timeout clock, rx_done wins and the byte is processed normally.
- The abort byte itself is not re-examined as a header, even if it is 55.
- frame_vld and frame_err are never asserted in the same clock.
- Reset asserted mid-frame: immediate return to reset values, including rx_frame_data.

Decomposition:
- Shared package uart_frame_pkg holds:
  - the header constants 55, BB, 02, 1A and the tail constant F0;
  - FRAME_LEN = 32, PAY_LEN = 26, CRC_POS = 30;
  - the err_code enumeration;
  - the FSM state typedef.
  The packer uses the same package.
- One natural sub-module: uart_rx_timeout, the gap counter, with a clear input and an expired pulse output.
- The CRC engine stays external (crc8_d8_rx) and is shared in form with the tx path.

Test Plan:
- Good frame: send 55 BB 02 1A, payload 00..19, the CRC from the bench crc8 model (poly 07, init 00), then F0 -> frame_vld once; rx_frame_data[7:0]=00 and [207:200]=19; ok_cnt=1; exactly 28 rx_crc_din_vld pulses; rx_crc_done pulses at the 55 byte and at the tail.
- CRC error: same frame with the CRC byte XOR 01 -> frame_err, err_code=1, err_cnt=1, rx_frame_data still equal to the previous good payload, no frame_vld.
- Tail error: correct CRC followed by tail F1 -> frame_err, err_code=2. A good frame sent next -> frame_vld, ok_cnt increments.
- Header hunting: stream AA 55 55 BB 02 1A followed by a good remainder -> frame accepted; AA ignored, second 55 re-syncs. Stream 55 BB 03 -> return to IDLE, no frame_err.
- Timeout: good header plus 10 payload bytes, then idle for TIMEOUT_CYC clocks -> frame_err, err_code=3, rx_crc_done pulse. A gap of TIMEOUT_CYC-2 clocks is tolerated. rx_done on the expiry clock -> no abort.
- Reset mid-PAY (reset low for 3 clocks) -> all outputs 0 immediately. A following good frame is accepted with ok_cnt=1.
